// File: rtl/cop0_exc_unit.sv
// MIPS Coprocessor 0: BadVAddr/Count/Compare/SR/Cause/EPC, exception and interrupt
// prioritisation, and the kernel entry/ERET redirect-and-flush sequencer.
module cop0_exc_unit #(
    parameter int                 N_EXC        = 3,
    parameter logic [N_EXC*5-1:0] EXC_CODES    = {5'd12, 5'd10, 5'd8},
    parameter logic [N_EXC-1:0]   BADADDR_MASK = '0,
    parameter int                 N_IRQ        = 5,
    parameter logic [31:0]        KERNEL_VEC   = 32'h8000_0180,
    parameter int                 FLUSH_CYCLES = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                mtc0_en,
    input  logic [4:0]                          wreg,
    input  logic [31:0]                         wdata,
    input  logic [4:0]                          rreg,
    output logic [31:0]                         rdata,
    input  logic [N_EXC-1:0]                    exc_req,
    input  logic [31:0]                         exc_pc,
    input  logic [31:0]                         exc_badaddr,
    input  logic [((N_IRQ > 0) ? N_IRQ : 1)-1:0] irq,
    input  logic                                eret,
    output logic                                redirect,
    output logic [31:0]                         redirect_pc,
    output logic                                flush,
    output logic                                kernel_mode,
    output logic [31:0]                         epc
);

    typedef enum logic {S_IDLE, S_FLUSH} state_t;

    state_t      state_q, state_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic        redirect_q, redirect_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] epc_q, epc_d;
    logic        sr_ie_q, sr_ie_d;
    logic        sr_exl_q, sr_exl_d;
    logic        sr_um_q, sr_um_d;
    logic [7:0]  sr_im_q, sr_im_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  ip_irq_q, ip_irq_d;
    logic        timer_q, timer_d;

    logic [7:0]  ip;
    logic        irq_pend;
    logic        exc_any;
    logic [4:0]  exc_code_sel;
    logic        exc_ld_bad;
    logic        wr_count, wr_compare, wr_sr, wr_cause, wr_epc;

    // External lines land on IP[6:2]; unused positions stay zero.
    for (genvar k = 0; k < 5; k++) begin : g_irq_map
        if (k < N_IRQ) begin : g_used
            assign ip_irq_d[k] = irq[k];
        end else begin : g_unused
            assign ip_irq_d[k] = 1'b0;
        end
    end

    assign ip       = {timer_q, ip_irq_q, ip_sw_q};
    assign irq_pend = sr_ie_q & ~sr_exl_q & |(ip & sr_im_q);
    assign exc_any  = |exc_req;

    assign wr_count   = mtc0_en && (wreg == 5'd9);
    assign wr_compare = mtc0_en && (wreg == 5'd11);
    assign wr_sr      = mtc0_en && (wreg == 5'd12);
    assign wr_cause   = mtc0_en && (wreg == 5'd13);
    assign wr_epc     = mtc0_en && (wreg == 5'd14);

    // Walk from the lowest-priority source upward so the lowest set index wins.
    always_comb begin
        exc_code_sel = 5'd0;
        exc_ld_bad   = 1'b0;
        for (int i = N_EXC - 1; i >= 0; i--) begin
            if (exc_req[i]) begin
                exc_code_sel = EXC_CODES[i*5 +: 5];
                exc_ld_bad   = BADADDR_MASK[i];
            end
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        count_d       = wr_count ? wdata : count_q + 32'd1;
        compare_d     = wr_compare ? wdata : compare_q;
        timer_d       = wr_compare ? 1'b0 : (timer_q | (count_q == compare_q));
        sr_ie_d       = wr_sr ? wdata[0] : sr_ie_q;
        sr_exl_d      = wr_sr ? wdata[1] : sr_exl_q;
        sr_um_d       = wr_sr ? wdata[4] : sr_um_q;
        sr_im_d       = wr_sr ? wdata[15:8] : sr_im_q;
        ip_sw_d       = wr_cause ? wdata[9:8] : ip_sw_q;
        epc_d         = wr_epc ? wdata : epc_q;
        badvaddr_d    = badvaddr_q;
        exccode_d     = exccode_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (exc_any || irq_pend || eret) begin
                    redirect_d  = 1'b1;
                    state_d     = S_FLUSH;
                    flush_cnt_d = 3'(FLUSH_CYCLES - 1);
                    if (exc_any) begin
                        exccode_d = exc_code_sel;
                        if (!sr_exl_q) epc_d = exc_pc;
                        if (exc_ld_bad) badvaddr_d = exc_badaddr;
                        sr_exl_d      = 1'b1;
                        redirect_pc_d = KERNEL_VEC;
                    end else if (irq_pend) begin
                        exccode_d     = 5'd0;
                        epc_d         = exc_pc;
                        sr_exl_d      = 1'b1;
                        redirect_pc_d = KERNEL_VEC;
                    end else begin
                        sr_exl_d      = 1'b0;
                        redirect_pc_d = epc_q;
                    end
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q == 3'd0) state_d = S_IDLE;
                else flush_cnt_d = flush_cnt_q - 3'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q       <= S_IDLE;
            flush_cnt_q   <= 3'd0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'd0;
            badvaddr_q    <= 32'd0;
            count_q       <= 32'd0;
            compare_q     <= 32'd0;
            epc_q         <= 32'd0;
            sr_ie_q       <= 1'b0;
            sr_exl_q      <= 1'b0;
            sr_um_q       <= 1'b1;
            sr_im_q       <= 8'd0;
            exccode_q     <= 5'd0;
            ip_sw_q       <= 2'd0;
            ip_irq_q      <= 5'd0;
            timer_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            badvaddr_q    <= badvaddr_d;
            count_q       <= count_d;
            compare_q     <= compare_d;
            epc_q         <= epc_d;
            sr_ie_q       <= sr_ie_d;
            sr_exl_q      <= sr_exl_d;
            sr_um_q       <= sr_um_d;
            sr_im_q       <= sr_im_d;
            exccode_q     <= exccode_d;
            ip_sw_q       <= ip_sw_d;
            ip_irq_q      <= ip_irq_d;
            timer_q       <= timer_d;
        end
    end

    always_comb begin
        unique case (rreg)
            5'd8:    rdata = badvaddr_q;
            5'd9:    rdata = count_q;
            5'd11:   rdata = compare_q;
            5'd12:   rdata = {16'd0, sr_im_q, 3'd0, sr_um_q, 2'd0, sr_exl_q, sr_ie_q};
            5'd13:   rdata = {16'd0, ip, 1'b0, exccode_q, 2'd0};
            5'd14:   rdata = epc_q;
            default: rdata = 32'd0;
        endcase
    end

    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign flush       = (state_q == S_FLUSH);
    assign kernel_mode = ~sr_um_q | sr_exl_q;
    assign epc         = epc_q;

endmodule

// File: tb/tb_cop0_exc_unit.sv
// Randomised bench for cop0_exc_unit: an architectural reference model feeds a
// scoreboard that a negedge monitor drains, plus a redirect-target queue.
module tb_cop0_exc_unit;

    localparam int                 N_EXC        = 3;
    localparam logic [N_EXC*5-1:0] EXC_CODES    = {5'd12, 5'd10, 5'd8};
    localparam logic [N_EXC-1:0]   BADADDR_MASK = 3'b101;
    localparam int                 N_IRQ        = 5;
    localparam logic [31:0]        KERNEL_VEC   = 32'h8000_0180;
    localparam int                 FLUSH_CYCLES = 2;
    localparam logic [31:0]        SR_MASK      = 32'h0000_FF13;

    logic             clk = 1'b0;
    logic             reset;
    logic             mtc0_en;
    logic [4:0]       wreg;
    logic [31:0]      wdata;
    logic [4:0]       rreg;
    logic [31:0]      rdata;
    logic [N_EXC-1:0] exc_req;
    logic [31:0]      exc_pc;
    logic [31:0]      exc_badaddr;
    logic [N_IRQ-1:0] irq;
    logic             eret;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic             flush;
    logic             kernel_mode;
    logic [31:0]      epc;

    cop0_exc_unit #(
        .N_EXC(N_EXC), .EXC_CODES(EXC_CODES), .BADADDR_MASK(BADADDR_MASK),
        .N_IRQ(N_IRQ), .KERNEL_VEC(KERNEL_VEC), .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .mtc0_en(mtc0_en), .wreg(wreg), .wdata(wdata),
        .rreg(rreg), .rdata(rdata), .exc_req(exc_req), .exc_pc(exc_pc),
        .exc_badaddr(exc_badaddr), .irq(irq), .eret(eret), .redirect(redirect),
        .redirect_pc(redirect_pc), .flush(flush), .kernel_mode(kernel_mode), .epc(epc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] rpc;
        logic [31:0] epc;
        logic        redirect;
        logic        flush;
        logic        kmode;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] target_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    // Architectural model state: whole register words, not RTL fields.
    logic [31:0] m_bad, m_count, m_compare, m_sr, m_cause, m_epc, m_rpc;
    logic        m_redirect;
    int          m_flush_left;
    logic [4:0]  code_tab [N_EXC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] r);
        case (r)
            5'd8:    return m_bad;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        logic [31:0] n_count, n_compare, n_sr, n_cause, n_epc, n_bad, target;
        logic [7:0]  ip;
        logic        pending, accept;
        int          first;
        if (reset) begin
            m_bad = 0; m_count = 0; m_compare = 0; m_sr = 32'h10; m_cause = 0;
            m_epc = 0; m_rpc = 0; m_redirect = 0; m_flush_left = 0;
            return;
        end
        ip      = m_cause[15:8];
        pending = m_sr[0] && !m_sr[1] && ((ip & m_sr[15:8]) != 0);
        accept  = (m_flush_left == 0) && (exc_req != 0 || pending || eret);

        n_count   = (mtc0_en && wreg == 9) ? wdata : m_count + 1;
        n_compare = (mtc0_en && wreg == 11) ? wdata : m_compare;
        n_sr      = (mtc0_en && wreg == 12) ? (wdata & SR_MASK) : m_sr;
        n_epc     = (mtc0_en && wreg == 14) ? wdata : m_epc;
        n_bad     = m_bad;
        n_cause   = m_cause;
        if (mtc0_en && wreg == 13) n_cause[9:8] = wdata[9:8];
        if (mtc0_en && wreg == 11) n_cause[15] = 1'b0;
        else if (m_count == m_compare) n_cause[15] = 1'b1;
        n_cause[14:10] = irq;

        m_redirect   = 1'b0;
        m_flush_left = (m_flush_left > 0) ? m_flush_left - 1 : 0;
        if (accept) begin
            if (exc_req != 0) begin
                first = -1;
                for (int i = 0; i < N_EXC; i++) if (first < 0 && exc_req[i]) first = i;
                n_cause[6:2] = code_tab[first];
                if (!m_sr[1]) n_epc = exc_pc;
                if (BADADDR_MASK[first]) n_bad = exc_badaddr;
                n_sr[1] = 1'b1;
                target  = KERNEL_VEC;
            end else if (pending) begin
                n_cause[6:2] = 5'd0;
                n_epc   = exc_pc;
                n_sr[1] = 1'b1;
                target  = KERNEL_VEC;
            end else begin
                n_sr[1] = 1'b0;
                target  = m_epc;
            end
            m_redirect   = 1'b1;
            m_flush_left = FLUSH_CYCLES;
            m_rpc        = target;
            target_q.push_back(target);
        end
        m_count = n_count; m_compare = n_compare; m_sr = n_sr;
        m_cause = n_cause; m_epc = n_epc; m_bad = n_bad;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Record what the DUT must show this cycle, then step the model.
    task automatic commit();
        exp_t e;
        e.rdata    = model_read(rreg);
        e.rpc      = m_rpc;
        e.epc      = m_epc;
        e.redirect = m_redirect;
        e.flush    = (m_flush_left > 0);
        e.kmode    = !m_sr[4] || m_sr[1];
        exp_q.push_back(e);
        model_step();
    endtask

    task automatic quiet();
        reset = 0; mtc0_en = 0; wreg = 0; wdata = 0; exc_req = 0; eret = 0;
    endtask

    task automatic idle(input int n, input logic [4:0] r);
        for (int i = 0; i < n; i++) begin
            next_cycle(); quiet(); rreg = r; commit();
        end
    endtask

    task automatic write(input logic [4:0] r, input logic [31:0] d);
        next_cycle(); quiet(); mtc0_en = 1; wreg = r; wdata = d; rreg = 5'd12; commit();
    endtask

    task automatic except(input logic [N_EXC-1:0] req, input logic [31:0] pc, input logic er);
        next_cycle(); quiet(); exc_req = req; exc_pc = pc; eret = er;
        exc_badaddr = $urandom; rreg = 5'd13; commit();
    endtask

    logic mon_en = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (mon_en && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rdata", rdata, e.rdata);
            check("redirect", {31'd0, redirect}, {31'd0, e.redirect});
            check("flush", {31'd0, flush}, {31'd0, e.flush});
            check("kernel_mode", {31'd0, kernel_mode}, {31'd0, e.kmode});
            check("epc", epc, e.epc);
            check("redirect_pc_hold", redirect_pc, e.rpc);
            if (redirect) begin
                if (target_q.size() == 0) check("redirect_unexpected", 32'd1, 32'd0);
                else check("redirect_target", redirect_pc, target_q.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < N_EXC; i++) code_tab[i] = EXC_CODES[i*5 +: 5];
        quiet();
        reset = 1; rreg = 0; exc_pc = 0; exc_badaddr = 0; irq = 0;
        model_step();
        repeat (3) @(posedge clk);
        mon_en = 1'b1;
        next_cycle(); quiet(); reset = 1; rreg = 5'd12; commit();

        // Reset state and Count start value.
        idle(1, 5'd12);
        idle(1, 5'd13);
        idle(1, 5'd9);
        idle(1, 5'd9);

        // Synchronous exceptions, nesting, ERET and priority over ERET.
        except(3'b110, 32'h0040_0020, 1'b0);
        except(3'b001, 32'h0040_0028, 1'b0);
        idle(3, 5'd14);
        except(3'b010, 32'h0040_0100, 1'b0);
        idle(3, 5'd8);
        write(5'd14, 32'h0040_0024);
        except(3'b000, 32'h0, 1'b1);
        idle(3, 5'd12);
        except(3'b100, 32'h0040_0200, 1'b1);
        idle(3, 5'd13);
        except(3'b000, 32'h0, 1'b1);
        idle(3, 5'd12);

        // External interrupt enabled, then masked.
        write(5'd12, 32'h0000_0401);
        next_cycle(); quiet(); irq = 5'b00001; exc_pc = 32'h0040_0300; rreg = 5'd13; commit();
        idle(4, 5'd13);
        except(3'b000, 32'h0, 1'b1);
        idle(3, 5'd12);
        write(5'd12, 32'h0000_0001);
        idle(4, 5'd13);
        irq = 0;

        // Timer: Compare 50, Count 45, then clear, then take it as an interrupt.
        write(5'd11, 32'd50);
        write(5'd9, 32'd45);
        idle(8, 5'd13);
        write(5'd11, 32'd1000);
        idle(2, 5'd13);
        write(5'd9, 32'd995);
        write(5'd12, 32'h0000_8001);
        idle(10, 5'd13);
        except(3'b000, 32'h0, 1'b1);
        idle(3, 5'd12);

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            logic [4:0] regs [7];
            regs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0};
            next_cycle();
            quiet();
            reset = ($urandom_range(0, 299) == 0);
            rreg  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : regs[$urandom_range(0, 6)];
            if ($urandom_range(0, 3) == 0) begin
                mtc0_en = 1;
                wreg    = ($urandom_range(0, 7) == 0) ? 5'($urandom) : regs[$urandom_range(0, 5)];
                wdata   = $urandom;
                if (wreg == 5'd11) wdata = m_count + $urandom_range(2, 20);
                if (wreg == 5'd9 && $urandom_range(0, 1) == 0) wdata = m_compare - $urandom_range(1, 10);
            end
            if ($urandom_range(0, 7) == 0) exc_req = N_EXC'($urandom);
            eret        = ($urandom_range(0, 7) == 0);
            exc_pc      = $urandom;
            exc_badaddr = $urandom;
            if ($urandom_range(0, 15) == 0) irq = N_IRQ'($urandom);
            commit();
        end

        idle(6, 5'd12);
        @(negedge clk);
        @(negedge clk);
        check("redirects_outstanding", target_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
